// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
// Holds each grant for up to MAX_BURST words and never writes while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam int                     SLOTS     = 1 << ID_WIDTH;
  localparam logic [3:0]             LAST_BEAT = 4'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]    LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] gnt_q, gnt_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;

  logic [SLOTS-1:0]      valid_ext;
  logic [SLOTS-1:0]      ready_ext;
  logic [DATA_WIDTH-1:0] data_arr [SLOTS];
  logic [ID_WIDTH-1:0]   search_base;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  win_found;
  logic                  xfer;
  logic                  release_gnt;

  // Pad requester lanes to a power of two so gnt can index them directly.
  assign valid_ext = SLOTS'(req_valid);

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_REQ) begin : g_used
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign data_arr[i] = '0;
    end
  end

  // In GRANT the only arbitration is at release, where last becomes gnt.
  always_comb begin
    logic [ID_WIDTH-1:0] cand;
    search_base = (state_q == GRANT) ? gnt_q : last_q;
    win_found   = 1'b0;
    win_idx     = '0;
    cand        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(search_base) + k) % NUM_REQ);
      if (valid_ext[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign busy         = (state_q == GRANT);
  assign xfer         = busy & valid_ext[gnt_q] & ~fifo_full;
  assign release_gnt  = busy & ((xfer & (burst_cnt_q == LAST_BEAT)) | ~valid_ext[gnt_q]);
  assign ready_ext    = (busy & ~fifo_full) ? (SLOTS'(1) << gnt_q) : '0;
  assign req_ready    = ready_ext[NUM_REQ-1:0];
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = busy ? data_arr[gnt_q] : '0;
  assign grant_id     = busy ? gnt_q : '0;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE) begin
      if (arb_en && win_found) begin
        state_d     = GRANT;
        gnt_d       = win_idx;
        burst_cnt_d = '0;
      end
    end else if (release_gnt) begin
      last_d      = gnt_q;
      burst_cnt_d = '0;
      if (arb_en && win_found) begin
        gnt_d = win_idx;
      end else begin
        state_d = IDLE;
      end
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_q      <= LAST_INIT;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a behavioural model predicts every cycle's
// outputs and every FIFO write; a separate monitor compares DUT activity against them.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic             wr_clk = 1'b0;
  logic             wr_rst = 1'b0;
  logic             arb_en = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic [IW-1:0]    grant_id;
  logic             busy;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .ID_WIDTH(IW)
  ) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .arb_en(arb_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          busy;
    logic [IW-1:0] id;
    logic [NR-1:0] ready;
    logic          wr;
    logic [DW-1:0] data;
  } st_t;

  wr_t exp_wr[$];
  st_t exp_st[$];
  logic [DW-1:0] src [NR][$];
  logic [NR-1:0] pend_pop = '0;

  int checks = 0;
  int errors = 0;

  // Model state: who owns the port, who owned it last, words written in this grant.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_count;

  st_t st_pop;
  wr_t wr_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int winner(input int base, input logic [NR-1:0] v);
    for (int off = 1; off <= NR; off++) begin
      int idx;
      idx = (base + off) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NR - 1;
    m_count = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, then advance to the next cycle.
  task automatic model_step();
    st_t s;
    logic xf;
    int w;
    s       = '0;
    s.busy  = m_busy;
    s.id    = m_busy ? IW'(m_owner) : '0;
    if (m_busy && !fifo_full) s.ready[m_owner] = 1'b1;
    xf      = m_busy && req_valid[m_owner] && !fifo_full;
    s.wr    = xf;
    s.data  = m_busy ? req_data[m_owner*DW +: DW] : '0;
    exp_st.push_back(s);
    if (xf) begin
      exp_wr.push_back('{id: IW'(m_owner), data: req_data[m_owner*DW +: DW]});
      m_count++;
    end
    if (m_busy) begin
      if ((xf && m_count == MB) || !req_valid[m_owner]) begin
        m_last  = m_owner;
        m_count = 0;
        w = winner(m_owner, req_valid);
        if (arb_en && w >= 0) m_owner = w;
        else m_busy = 1'b0;
      end
    end else begin
      w = winner(m_last, req_valid);
      if (arb_en && w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_count = 0;
      end
    end
  endtask

  // One clock of randomized stimulus; requesters pop a word only on a DUT handshake.
  task automatic apply_stimulus(input int p_valid, input int p_full, input int p_en,
                                input logic [NR-1:0] mask);
    @(negedge wr_clk);
    for (int i = 0; i < NR; i++) begin
      if (pend_pop[i]) void'(src[i].pop_front());
      while (src[i].size() < 4) src[i].push_back(DW'($urandom_range(0, 255)));
      if (mask[i] && ($urandom_range(0, 99) < p_valid)) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = src[i][0];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = DW'($urandom_range(0, 255));
      end
    end
    fifo_full = ($urandom_range(0, 99) < p_full);
    arb_en    = ($urandom_range(0, 99) < p_en);
    #1;
    model_step();
    pend_pop = req_valid & req_ready;
  endtask

  task automatic check_output_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Monitor: compares per-cycle status and every FIFO write against the scoreboard.
  always @(negedge wr_clk) begin
    #2;
    if (exp_st.size() > 0) begin
      st_pop = exp_st.pop_front();
      check("busy", 32'(busy), 32'(st_pop.busy));
      check("grant_id", 32'(grant_id), 32'(st_pop.id));
      check("req_ready", 32'(req_ready), 32'(st_pop.ready));
      check("fifo_wr_en", 32'(fifo_wr_en), 32'(st_pop.wr));
      check("fifo_wr_data", 32'(fifo_wr_data), 32'(st_pop.data));
    end
    if (fifo_wr_en) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual=%0h expected=none", fifo_wr_data);
      end else begin
        wr_pop = exp_wr.pop_front();
        check("write_id", 32'(grant_id), 32'(wr_pop.id));
        check("write_data", 32'(fifo_wr_data), 32'(wr_pop.data));
      end
    end
  end

  // Drive a grant of req0 to two words, then reset asynchronously mid-burst.
  task automatic mid_burst_reset();
    int n;
    n = 0;
    do begin
      apply_stimulus(100, 0, 100, 4'b0001);
      n++;
    end while (!(m_busy && m_count == 2) && n < 200);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL mid_burst_wait actual=%0d expected=<200", n);
    end
    @(posedge wr_clk);
    #3;
    wr_rst = 1'b0;
    #1;
    check_output_idle("async_reset");
    model_reset();
    req_valid = 4'b0001;
    arb_en    = 1'b1;
    fifo_full = 1'b0;
    repeat (2) begin
      @(negedge wr_clk);
      #3;
      check_output_idle("held_reset");
    end
    @(negedge wr_clk);
    req_valid = '0;
    arb_en    = 1'b0;
    wr_rst    = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_output_idle("reset");
    @(negedge wr_clk);
    wr_rst = 1'b1;

    // Sole requester: bursts of MB then back-to-back re-grant to itself.
    repeat (12) apply_stimulus(100, 0, 100, 4'b0001);
    // All requesters continuously valid: strict rotation.
    repeat (24) apply_stimulus(100, 0, 100, 4'b1111);
    // Single requester with heavy back-pressure.
    repeat (24) apply_stimulus(100, 40, 100, 4'b0010);
    // Two requesters, intermittent valid so grants release early.
    repeat (40) apply_stimulus(60, 0, 100, 4'b1100);
    // arb_en toggling while requests pending.
    repeat (60) apply_stimulus(90, 10, 40, 4'b1111);
    mid_burst_reset();
    // req0 and req3 both valid right after reset: req0 must be granted first.
    repeat (10) apply_stimulus(100, 0, 100, 4'b1001);
    // General random traffic.
    repeat (400) apply_stimulus(70, 20, 80, 4'b1111);
    repeat (4) apply_stimulus(0, 0, 100, 4'b0000);

    @(negedge wr_clk);
    #3;
    check("writes_drained", 32'(exp_wr.size()), 32'd0);
    check("status_drained", 32'(exp_st.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
